fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have stall, input, 1 bit: from the hazard unit; when high, PC and the IF/ID register hold.
REQ-004 The module SHALL have br_tkn, input, 1 bit: from the ID-stage control decoder; high means redirect fetch.
REQ-005 The module SHALL have unc_br, input, 1 bit: from the decoder; high selects the B offset, low selects the CB/B.cond offset.
REQ-006 The module SHALL have imem_addr, output, 64 bits: the current PC, driven combinationally from the PC register.
REQ-007 The module SHALL have imem_data, input, 32 bits: the instruction at imem_addr, combinational read, same cycle.
REQ-008 The module SHALL have if_id_instr, output, 32 bits: the instruction presented to the decoder.
REQ-009 The module SHALL have if_id_pc, output, 64 bits: the fetch address of if_id_instr.
REQ-010 The module SHALL have if_id_valid, output, 1 bit: high when if_id_instr is a real fetched instruction and not a bubble.
REQ-011 The module SHALL have fetch_cnt, output, 32 bits: the count of valid instructions latched into IF/ID.
REQ-012 The module SHALL have flush_cnt, output, 32 bits: the count of redirect flushes.

Function
REQ-013 Branch target SHALL be if_id_pc + (SignExt(offset) << 2), computed modulo 2^64.
- If unc_br=1, offset = if_id_instr[25:0], with sign bit 25.
- If unc_br=0, offset = if_id_instr[23:5], with sign bit 23.
REQ-014 A redirect SHALL occur when br_tkn=1, if_id_valid=1 and stall=0.
REQ-015 Next-state priority SHALL be stall, then redirect, then sequential.
REQ-016 On stall, pc, if_id_instr, if_id_pc, if_id_valid and both counters SHALL hold.
- Any pending branch SHALL stay pending, because IF/ID is held and the decoder output is unchanged.
REQ-017 On redirect:
- pc SHALL load the branch target.
- if_id_instr SHALL load 32'h0, the decoder no-op encoding.
- if_id_pc SHALL load 0 and if_id_valid SHALL load 0.
- flush_cnt SHALL increment.
REQ-018 On a sequential cycle:
- if_id_instr SHALL load imem_data and if_id_pc SHALL load pc.
- if_id_valid SHALL load 1 and fetch_cnt SHALL increment.
- pc SHALL load pc+4, modulo 2^64.
REQ-019 There SHALL be no branch delay slot: the instruction fetched in the redirect cycle is discarded.
REQ-020 Branch resolution latency SHALL be 1 cycle: the target is fetched in the cycle after the branch occupies ID.
REQ-021 The block SHALL have three states:
- RST: entered on reset.
- RUN: normal fetch.
- BUBBLE: entered after a redirect.
REQ-022 State transitions SHALL be:
- RST goes to RUN on the first edge after reset deasserts.
- RUN goes to BUBBLE on a redirect.
- BUBBLE goes to RUN on the next non-stall edge.
- In all states, stall holds the current state.
REQ-023 br_tkn SHALL be ignored while if_id_valid=0, so a bubble never causes a redirect.
REQ-024 fetch_cnt and flush_cnt SHALL wrap from 32'hFFFFFFFF to 0 without saturation.
REQ-025 A PC wrap from 64'hFFFFFFFFFFFFFFFC to 0 SHALL be silent, with no error flag.

Reset
REQ-026 While reset=1, asynchronously and independent of clk, the following SHALL all be 0:
- pc and imem_addr
- if_id_instr and if_id_pc
- if_id_valid
- fetch_cnt and flush_cnt
REQ-027 Reset asserted mid-operation SHALL discard any pending redirect or stall; state SHALL be RST.
REQ-028 On the first edge after reset deasserts, with stall=0, the block SHALL latch the instruction at address 0, and pc SHALL become 4.

Verification
REQ-029 Sequential fetch: reset, then release with stall=0, imem returning 0x91000421.
- pc SHALL go 0, 4, 8, 12.
- if_id_pc SHALL go 0, 4, 8.
- if_id_valid SHALL be 1 from the first edge.
- fetch_cnt SHALL be 3 after 3 edges.
REQ-030 Unconditional branch: if_id_instr=0x17FFFFFE (B with offset -2) at if_id_pc=0x10, br_tkn=1, unc_br=1.
- Next pc SHALL be 0x08.
- if_id_valid SHALL be 0 and if_id_instr SHALL be 0.
- flush_cnt SHALL be 1.
- The following cycle SHALL latch the instruction at 0x08.
REQ-031 Conditional branch: if_id_instr=0xB4000060 (CBZ, CondAddr19=3) at if_id_pc=0x20, br_tkn=1, unc_br=0.
- Next pc SHALL be 0x2C.
REQ-032 Stall with branch: stall=1 with br_tkn=1 held for 3 cycles.
- All outputs SHALL be unchanged during the stall.
- On the first edge after stall falls, the redirect SHALL occur.
REQ-033 Reset mid-flight: reset asserted between edges during a redirect cycle.
- All outputs SHALL go to 0 immediately.
- After release, fetch SHALL restart at 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with the IF/ID pipeline register.
//
// Fetches one instruction per cycle from a combinational instruction memory
// and latches it, with its fetch address, into IF/ID. A taken branch decoded
// in ID redirects the PC to the branch target one cycle later. The word
// fetched in that redirect cycle is dropped, and IF/ID is loaded with a bubble.
//
// Ports
//   clk          in   1   clock; all state updates on the rising edge
//   reset        in   1   asynchronous, active-high reset
//   stall        in   1   hazard-unit stall; holds PC, IF/ID and counters
//   br_tkn       in   1   decoder: branch in ID is taken
//   unc_br       in   1   decoder: 1 = B (imm26), 0 = CB/B.cond (imm19)
//   imem_addr    out  64  current PC
//   imem_data    in   32  instruction at imem_addr (same-cycle read)
//   if_id_instr  out  32  instruction presented to the decoder
//   if_id_pc     out  64  fetch address of if_id_instr
//   if_id_valid  out  1   if_id_instr is a real instruction (not a bubble)
//   fetch_cnt    out  32  valid instructions latched into IF/ID (wraps)
//   flush_cnt    out  32  redirect flushes (wraps)
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_tkn,
    input  logic        unc_br,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] flcnt_q, flcnt_d;

    logic        redirect;
    logic [63:0] br_off;
    logic [63:0] br_target;

    // A bubble in IF/ID can never redirect, whatever the decoder says.
    assign redirect = br_tkn & valid_q & ~stall;

    // Sign-extended word offset, already scaled by 4.
    assign br_off = unc_br ? {{36{instr_q[25]}}, instr_q[25:0], 2'b00}
                           : {{43{instr_q[23]}}, instr_q[23:5], 2'b00};
    assign br_target = ipc_q + br_off;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        flcnt_d = flcnt_q;
        state_d = state_q;

        if (!stall) begin
            if (redirect) begin
                pc_d    = br_target;
                instr_d = 32'h0;
                ipc_d   = 64'h0;
                valid_d = 1'b0;
                flcnt_d = flcnt_q + 32'd1;
            end else begin
                pc_d    = pc_q + 64'd4;
                instr_d = imem_data;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                fcnt_d  = fcnt_q + 32'd1;
            end

            case (state_q)
                ST_RST:    state_d = ST_RUN;
                ST_RUN:    state_d = redirect ? ST_BUBBLE : ST_RUN;
                ST_BUBBLE: state_d = ST_RUN;
                default:   state_d = ST_RST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
            pc_q    <= 64'h0;
            instr_q <= 32'h0;
            ipc_q   <= 64'h0;
            valid_q <= 1'b0;
            fcnt_q  <= 32'h0;
            flcnt_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            flcnt_q <= flcnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign fetch_cnt   = fcnt_q;
    assign flush_cnt   = flcnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed sequences with literal expectations,
// then randomized stall/branch traffic checked every cycle against a
// behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_tkn;
    logic        unc_br;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    int mem_mode;
    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr, m_fcnt, m_flcnt;
    logic        m_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_tkn     (br_tkn),
        .unc_br     (unc_br),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .fetch_cnt  (fetch_cnt),
        .flush_cnt  (flush_cnt)
    );

    // Instruction memory contents: 0 = constant word, 1 = branch table for
    // the directed tests, 2 = address hash for random traffic.
    function automatic logic [31:0] mem_fn(input logic [63:0] a, input int mode);
        if (mode == 0) return 32'h91000421;
        if (mode == 1) begin
            if (a == 64'h10) return 32'h17FFFFFE;
            if (a == 64'h20) return 32'hB4000060;
            return 32'h91000421;
        end
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5BD1E995;
    endfunction

    always_comb imem_data = mem_fn(imem_addr, mem_mode);

    task automatic model_reset();
        m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
        m_valid = 1'b0; m_fcnt = 32'h0; m_flcnt = 32'h0;
    endtask

    // One rising edge of the fetch rules.
    task automatic model_edge();
        longint off;
        if (stall) return;
        if (br_tkn && m_valid) begin
            if (unc_br) begin
                off = longint'(m_instr[25:0]);
                if (m_instr[25]) off = off - (longint'(1) << 26);
            end else begin
                off = longint'(m_instr[23:5]);
                if (m_instr[23]) off = off - (longint'(1) << 19);
            end
            m_pc    = m_ipc + 64'(off * 4);
            m_instr = 32'h0;
            m_ipc   = 64'h0;
            m_valid = 1'b0;
            m_flcnt = m_flcnt + 32'd1;
        end else begin
            m_instr = mem_fn(m_pc, mem_mode);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 32'd1;
            m_pc    = m_pc + 64'd4;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m.pc",    imem_addr,            m_pc);
        chk("m.instr", 64'(if_id_instr),     64'(m_instr));
        chk("m.ipc",   if_id_pc,             m_ipc);
        chk("m.valid", 64'(if_id_valid),     64'(m_valid));
        chk("m.fcnt",  64'(fetch_cnt),       64'(m_fcnt));
        chk("m.flcnt", 64'(flush_cnt),       64'(m_flcnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pc"},    imem_addr,        64'h0);
        chk({tag, ".instr"}, 64'(if_id_instr), 64'h0);
        chk({tag, ".ipc"},   if_id_pc,         64'h0);
        chk({tag, ".valid"}, 64'(if_id_valid), 64'h0);
        chk({tag, ".fcnt"},  64'(fetch_cnt),   64'h0);
        chk({tag, ".flcnt"}, 64'(flush_cnt),   64'h0);
    endtask

    // Inputs only change just after a falling edge, so they are stable here.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    // Assert reset between edges, check outputs clear at once, release later.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 chk_zero(tag);
        br_tkn = 1'b0;
        stall  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_tkn = 1'b0; unc_br = 1'b0;
        mem_mode = 1;
        model_reset();
        #1 chk_zero("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Sequential fetch from 0
        step(); chk("seq1.pc", imem_addr, 64'h4); chk("seq1.ipc", if_id_pc, 64'h0);
        chk("seq1.valid", 64'(if_id_valid), 64'h1);
        chk("seq1.instr", 64'(if_id_instr), 64'h91000421);
        step(); chk("seq2.pc", imem_addr, 64'h8); chk("seq2.ipc", if_id_pc, 64'h4);
        step(); chk("seq3.pc", imem_addr, 64'hC); chk("seq3.ipc", if_id_pc, 64'h8);
        chk("seq3.fcnt", 64'(fetch_cnt), 64'd3);

        // Unconditional branch B -2 at 0x10
        step(); step();
        chk("b.ipc", if_id_pc, 64'h10); chk("b.instr", 64'(if_id_instr), 64'h17FFFFFE);
        br_tkn = 1'b1; unc_br = 1'b1;
        step();
        chk("b.pc", imem_addr, 64'h8); chk("b.valid", 64'(if_id_valid), 64'h0);
        chk("b.instr0", 64'(if_id_instr), 64'h0); chk("b.flcnt", 64'(flush_cnt), 64'd1);
        // br_tkn still high over the bubble: must be ignored
        step();
        chk("bub.ipc", if_id_pc, 64'h8); chk("bub.valid", 64'(if_id_valid), 64'h1);
        chk("bub.pc", imem_addr, 64'hC); chk("bub.flcnt", 64'(flush_cnt), 64'd1);
        br_tkn = 1'b0;

        // Conditional CBZ +3 at 0x20, held by a 3-cycle stall first
        repeat (6) step();
        chk("cb.ipc", if_id_pc, 64'h20); chk("cb.instr", 64'(if_id_instr), 64'hB4000060);
        stall = 1'b1; br_tkn = 1'b1; unc_br = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl.pc", imem_addr, 64'h24); chk("stl.ipc", if_id_pc, 64'h20);
            chk("stl.fcnt", 64'(fetch_cnt), 64'd12); chk("stl.flcnt", 64'(flush_cnt), 64'd1);
            chk("stl.valid", 64'(if_id_valid), 64'h1);
        end
        stall = 1'b0;
        step();
        chk("cb.pc", imem_addr, 64'h2C); chk("cb.flcnt", 64'(flush_cnt), 64'd2);
        chk("cb.valid", 64'(if_id_valid), 64'h0);
        br_tkn = 1'b0;
        step();
        chk("cb2.ipc", if_id_pc, 64'h2C);

        // Reset in the middle of a redirect cycle
        br_tkn = 1'b1;
        mid_reset("mrst");
        step();
        chk("rst2.pc", imem_addr, 64'h4); chk("rst2.ipc", if_id_pc, 64'h0);
        chk("rst2.fcnt", 64'(fetch_cnt), 64'd1); chk("rst2.valid", 64'(if_id_valid), 64'h1);

        // Random traffic
        mem_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            br_tkn = ($urandom_range(0, 2) == 0);
            unc_br = 1'($urandom);
            if ($urandom_range(0, 499) == 0) mid_reset("rrst");
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
